// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for the N-input priority arbiter.
// Imported by the scan sub-module and the top level.
package prio_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MAX_N = 64;

    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx,
                                                input int unsigned n);
        return (idx < n) ? (MAX_N'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational downward scan with modulo-N wrap.
// Fixed mode always starts at N-1; round-robin starts at start_i.
module prio_pick
    import prio_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec_i,
    input  logic [IDX_W-1:0] start_i,
    input  logic             mode_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    logic [IDX_W-1:0] pos;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = (mode_i == MODE_RR) ? start_i : LAST;
        for (int k = 0; k < N; k++) begin
            if (!found_o && vec_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
            // Wrap from 0 lands on N-1, never on 2^IDX_W-1.
            pos = (pos == '0) ? LAST : pos - ONE;
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-input priority arbiter with fixed/round-robin mode.
// A winner is latched and held until the consumer signals done.
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     req_mask,
    input  logic             rr_mode,
    input  logic             done,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     grant,
    output logic             valid
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             valid_q, valid_d;

    logic [N-1:0]     eff;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;

    assign eff   = req & req_mask;
    // Previous winner gets the lowest priority in round-robin.
    assign start = (last_q == '0) ? LAST : last_q - ONE;

    prio_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec_i   (eff),
        .start_i (start),
        .mode_i  (rr_mode),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        grant_d = grant_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    grant_d = N'(onehot(32'(win_idx), N));
                    valid_d = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    last_d  = idx_q;
                    grant_d = '0;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign idx   = idx_q;
    assign grant = grant_q;
    assign valid = valid_q;

endmodule
